// File: rtl/rrelu_pkg.sv
// Shared definitions for the residual add + ReLU stage that post-processes
// the core's OP_SRAM rows.
//   - Geometry constants: lanes per row, lane widths, rows per pass.
//   - state_t: sequencer states.
//   - psum_row_t / res_row_t: packed row types for OP_SRAM and residual SRAM.
package rrelu_pkg;

    localparam int COL      = 8;
    localparam int PSUM_BW  = 16;
    localparam int RES_BW   = 4;
    localparam int NUM_ROWS = 16;
    localparam int ADDR_W   = 4;

    localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(NUM_ROWS - 1);

    typedef enum logic [2:0] {
        IDLE,
        RD,
        CAP,
        WR,
        DONE
    } state_t;

    typedef logic [COL*PSUM_BW-1:0] psum_row_t;
    typedef logic [COL*RES_BW-1:0]  res_row_t;

endpackage

// File: rtl/residual_relu_unit_if.sv
// SRAM-side bundle of the residual/ReLU stage.
//   master: the stage (drives addresses, chip/write enables, write data).
//   slave : the memories (return op_q and res_q, one cycle after a read edge).
// Signals:
//   op_addr/op_cen/op_wen/op_d/op_q : single-port OP_SRAM, enables active-low
//   res_addr/res_cen/res_q          : read-only residual SRAM, enable active-low
interface residual_relu_unit_if;
    import rrelu_pkg::*;

    logic [ADDR_W-1:0] op_addr;
    logic              op_cen;
    logic              op_wen;
    psum_row_t         op_d;
    psum_row_t         op_q;
    logic [ADDR_W-1:0] res_addr;
    logic              res_cen;
    res_row_t          res_q;

    modport master (
        output op_addr, op_cen, op_wen, op_d, res_addr, res_cen,
        input  op_q, res_q
    );

    modport slave (
        input  op_addr, op_cen, op_wen, op_d, res_addr, res_cen,
        output op_q, res_q
    );

endinterface

// File: rtl/rrelu_lane.sv
// One lane of the residual stage: signed psum plus unsigned residual, then
// saturation (optional) and ReLU.
// Ports:
//   psum   in  signed psum lane
//   res    in  unsigned residual activation
//   result out ReLU'd lane value
//   clip   out lane hit the positive saturation limit
// Build option: RESIDUAL_SAT_EN selects saturation; without it the sum wraps
// to the lane width and the wrapped sign decides ReLU, and clip is constant 0.
module rrelu_lane
    import rrelu_pkg::*;
(
    input  logic [PSUM_BW-1:0] psum,
    input  logic [RES_BW-1:0]  res,
    output logic [PSUM_BW-1:0] result,
    output logic               clip
);

`ifdef RESIDUAL_SAT_EN
    logic [PSUM_BW:0] sum;

    assign sum = {psum[PSUM_BW-1], psum} + {{(PSUM_BW+1-RES_BW){1'b0}}, res};

    // The residual is non-negative, so the 17-bit sum can only overflow
    // upward: bit 16 set means genuinely negative, bit 15 set alone means
    // above the positive limit.
    always_comb begin
        result = sum[PSUM_BW-1:0];
        clip   = 1'b0;
        if (sum[PSUM_BW]) begin
            result = '0;
        end else if (sum[PSUM_BW-1]) begin
            result = {1'b0, {(PSUM_BW-1){1'b1}}};
            clip   = 1'b1;
        end
    end
`else
    logic [PSUM_BW-1:0] wrapped;

    assign wrapped = psum + {{(PSUM_BW-RES_BW){1'b0}}, res};
    assign result  = wrapped[PSUM_BW-1] ? '0 : wrapped;
    assign clip    = 1'b0;
`endif

endmodule

// File: rtl/residual_relu_unit.sv
// Residual add + ReLU sequencer. After start, walks all OP_SRAM rows with a
// read / capture / write-back cycle per row (the OP_SRAM is single-port, so
// reads and writes never overlap), adding the matching residual word lane-wise
// and writing the ReLU'd row back in place.
// Ports:
//   clk, reset   clock and asynchronous active-low reset
//   start        begin a pass (honoured only while idle)
//   busy         pass in progress
//   done         one-cycle pulse after the last row write
//   clip_cnt     saturated lanes in the latest pass (RESIDUAL_SAT_EN builds)
//   sram         OP_SRAM and residual SRAM port bundle (master side)
// Build option: RESIDUAL_SAT_EN enables saturation and the clip counter.
module residual_relu_unit
    import rrelu_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic [7:0]           clip_cnt,
    residual_relu_unit_if.master sram
);

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] row;
    logic [ADDR_W-1:0] row_nxt;
    psum_row_t         op_d_q;
    psum_row_t         lane_result;
    logic [COL-1:0]    lane_clip;
    logic              op_cen_c;
    logic              op_wen_c;
    logic              res_cen_c;

    for (genvar i = 0; i < COL; i++) begin : g_lane
        rrelu_lane u_lane (
            .psum   (sram.op_q[i*PSUM_BW +: PSUM_BW]),
            .res    (sram.res_q[i*RES_BW +: RES_BW]),
            .result (lane_result[i*PSUM_BW +: PSUM_BW]),
            .clip   (lane_clip[i])
        );
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            row   <= '0;
        end else begin
            state <= state_nxt;
            row   <= row_nxt;
        end
    end

    // Enables are decoded from the state so a reset releases the SRAMs in
    // the same instant it clears the state register.
    always_comb begin
        state_nxt = state;
        row_nxt   = row;
        busy      = 1'b0;
        done      = 1'b0;
        op_cen_c  = 1'b1;
        op_wen_c  = 1'b1;
        res_cen_c = 1'b1;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = RD;
                    row_nxt   = '0;
                end
            end
            RD: begin
                busy      = 1'b1;
                op_cen_c  = 1'b0;
                res_cen_c = 1'b0;
                state_nxt = CAP;
            end
            CAP: begin
                busy      = 1'b1;
                state_nxt = WR;
            end
            WR: begin
                busy     = 1'b1;
                op_cen_c = 1'b0;
                op_wen_c = 1'b0;
                if (row == LAST_ROW) begin
                    state_nxt = DONE;
                end else begin
                    row_nxt   = row + 1'b1;
                    state_nxt = RD;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Read data is valid during CAP; the lane results are latched here and
    // presented as write data during WR.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_d_q <= '0;
        end else if (state == CAP) begin
            op_d_q <= lane_result;
        end
    end

    assign sram.op_addr  = row;
    assign sram.res_addr = row;
    assign sram.op_cen   = op_cen_c;
    assign sram.op_wen   = op_wen_c;
    assign sram.res_cen  = res_cen_c;
    assign sram.op_d     = op_d_q;

`ifdef RESIDUAL_SAT_EN
    logic [3:0] clip_row;
    logic [8:0] clip_sum;
    logic [7:0] clip_cnt_q;

    always_comb begin
        clip_row = '0;
        for (int i = 0; i < COL; i++) begin
            clip_row = clip_row + {3'b000, lane_clip[i]};
        end
    end

    assign clip_sum = {1'b0, clip_cnt_q} + {5'b00000, clip_row};

    // Cleared only when a pass is accepted so the count survives past done.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            clip_cnt_q <= '0;
        end else if (state == IDLE && start) begin
            clip_cnt_q <= '0;
        end else if (state == CAP) begin
            clip_cnt_q <= clip_sum[8] ? 8'hFF : clip_sum[7:0];
        end
    end

    assign clip_cnt = clip_cnt_q;
`else
    logic unused_clip;

    assign unused_clip = ^lane_clip;
    assign clip_cnt    = '0;
`endif

endmodule

// File: tb/tb_residual_relu_unit.sv
// Self-checking bench for residual_relu_unit: SRAM behavioural models,
// a lane-arithmetic reference model, and scenario tasks.
// Honours RESIDUAL_SAT_EN the same way as the design.
module tb_residual_relu_unit;
    import rrelu_pkg::*;

    logic       clk;
    logic       reset;
    logic       start;
    logic       busy;
    logic       done;
    logic [7:0] clip_cnt;

    residual_relu_unit_if sif ();

    residual_relu_unit dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .clip_cnt (clip_cnt),
        .sram     (sif)
    );

    int errors = 0;
    int checks = 0;

    psum_row_t op_mem  [NUM_ROWS];
    res_row_t  res_mem [NUM_ROWS];
    psum_row_t exp_mem [NUM_ROWS];
    psum_row_t orig_mem[NUM_ROWS];
    int        exp_clip;
    int        wr_log[$];
    int        viol;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory models plus protocol monitor.
    always @(posedge clk) begin
        if (!sif.op_cen && !sif.op_wen && !sif.res_cen) viol++;
        if (!sif.op_cen && !sif.op_wen) begin
            op_mem[sif.op_addr] = sif.op_d;
            wr_log.push_back(int'(sif.op_addr));
        end else if (!sif.op_cen) begin
            sif.op_q <= op_mem[sif.op_addr];
        end
        if (!sif.res_cen) sif.res_q <= res_mem[sif.res_addr];
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Reference: integer arithmetic straight from the lane rules.
    function automatic void ref_row(input psum_row_t p_row, input res_row_t r_row,
                                    output psum_row_t out_row, output int clips);
        logic [15:0] p;
        logic [3:0]  r;
        int          s;
        clips   = 0;
        out_row = '0;
        for (int l = 0; l < COL; l++) begin
            p = p_row[l*16 +: 16];
            r = r_row[l*4 +: 4];
            s = int'($signed(p)) + int'(r);
`ifdef RESIDUAL_SAT_EN
            if (s > 32767) begin
                s = 32767;
                clips++;
            end
            if (s < 0) s = 0;
`else
            s = s & 32'hFFFF;
            if (s >= 32768) s = 0;
`endif
            out_row[l*16 +: 16] = s[15:0];
        end
    endfunction

    task automatic build_expected();
        int total;
        int n;
        total = 0;
        for (int i = 0; i < NUM_ROWS; i++) begin
            orig_mem[i] = op_mem[i];
            ref_row(op_mem[i], res_mem[i], exp_mem[i], n);
            total += n;
        end
        exp_clip = (total > 255) ? 255 : total;
    endtask

    task automatic fill_random();
        logic [15:0] p;
        for (int i = 0; i < NUM_ROWS; i++) begin
            for (int l = 0; l < COL; l++) begin
                p = 16'($urandom);
                if ($urandom_range(0, 3) == 0) p = {12'h7FF, 4'($urandom)};
                op_mem[i][l*16 +: 16] = p;
                res_mem[i][l*4 +: 4]  = 4'($urandom);
            end
        end
    endtask

    // Pulses start and waits (bounded) for done; counts are relative to the
    // accepting edge, so done is expected at count 49.
    task automatic run_pass(output int done_at, output int busy_cycles, output bit timed_out);
        done_at     = 0;
        busy_cycles = 0;
        timed_out   = 1'b1;
        wr_log.delete();
        viol = 0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c <= 200; c++) begin
            if (busy) busy_cycles++;
            if (done) begin
                done_at   = c;
                timed_out = 1'b0;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic check_rows(input string tag);
        for (int i = 0; i < NUM_ROWS; i++) begin
            checks++;
            if (op_mem[i] !== exp_mem[i]) begin
                errors++;
                $display("[TB] FAIL %s row %0d: got %h expected %h", tag, i, op_mem[i], exp_mem[i]);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        start = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b0)        begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0)        begin errors++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
        checks++; if (sif.op_cen !== 1'b1)  begin errors++; $display("[TB] FAIL reset_op_cen: got %b expected 1", sif.op_cen); end
        checks++; if (sif.op_wen !== 1'b1)  begin errors++; $display("[TB] FAIL reset_op_wen: got %b expected 1", sif.op_wen); end
        checks++; if (sif.res_cen !== 1'b1) begin errors++; $display("[TB] FAIL reset_res_cen: got %b expected 1", sif.res_cen); end
        checks++; if (sif.op_addr !== 4'd0) begin errors++; $display("[TB] FAIL reset_op_addr: got %h expected 0", sif.op_addr); end
        checks++; if (sif.op_d !== '0)      begin errors++; $display("[TB] FAIL reset_op_d: got %h expected 0", sif.op_d); end
        checks++; if (clip_cnt !== 8'd0)    begin errors++; $display("[TB] FAIL reset_clip_cnt: got %0d expected 0", clip_cnt); end
        reset = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_directed_row0();
        int          d_at;
        int          b_cnt;
        bit          to;
        logic [15:0] exp_l2;
        logic [7:0]  exp_c;
        for (int i = 0; i < NUM_ROWS; i++) begin
            op_mem[i]  = '0;
            res_mem[i] = '0;
        end
        op_mem[0][0*16 +: 16] = 16'h0005; res_mem[0][0*4 +: 4] = 4'h3;
        op_mem[0][1*16 +: 16] = 16'hFFF0; res_mem[0][1*4 +: 4] = 4'h2;
        op_mem[0][2*16 +: 16] = 16'h7FFE; res_mem[0][2*4 +: 4] = 4'hF;
`ifdef RESIDUAL_SAT_EN
        exp_l2 = 16'h7FFF;
        exp_c  = 8'd1;
`else
        exp_l2 = 16'h0000;
        exp_c  = 8'd0;
`endif
        run_pass(d_at, b_cnt, to);
        checks++; if (to !== 1'b0) begin errors++; $display("[TB] FAIL row0_timeout: got %b expected 0", to); end
        checks++; if (op_mem[0][0*16 +: 16] !== 16'h0008) begin errors++; $display("[TB] FAIL row0_lane0: got %h expected 0008", op_mem[0][0*16 +: 16]); end
        checks++; if (op_mem[0][1*16 +: 16] !== 16'h0000) begin errors++; $display("[TB] FAIL row0_lane1: got %h expected 0000", op_mem[0][1*16 +: 16]); end
        checks++; if (op_mem[0][2*16 +: 16] !== exp_l2)   begin errors++; $display("[TB] FAIL row0_lane2: got %h expected %h", op_mem[0][2*16 +: 16], exp_l2); end
        checks++; if (clip_cnt !== exp_c) begin errors++; $display("[TB] FAIL row0_clip_cnt: got %0d expected %0d", clip_cnt, exp_c); end
        @(negedge clk);
    endtask

    task automatic test_full_pass();
        int d_at;
        int b_cnt;
        bit to;
        for (int i = 0; i < NUM_ROWS; i++) begin
            op_mem[i]  = {COL{16'h0010}};
            res_mem[i] = {COL{4'h1}};
            exp_mem[i] = {COL{16'h0011}};
        end
        run_pass(d_at, b_cnt, to);
        checks++; if (to !== 1'b0)  begin errors++; $display("[TB] FAIL full_timeout: got %b expected 0", to); end
        checks++; if (d_at != 49)   begin errors++; $display("[TB] FAIL full_done_latency: got %0d expected 49", d_at); end
        checks++; if (b_cnt != 48)  begin errors++; $display("[TB] FAIL full_busy_cycles: got %0d expected 48", b_cnt); end
        checks++; if (clip_cnt !== 8'd0) begin errors++; $display("[TB] FAIL full_clip_cnt: got %0d expected 0", clip_cnt); end
        @(negedge clk);
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL full_done_width: got %b expected 0", done); end
        check_rows("full");
        checks++; if (viol != 0) begin errors++; $display("[TB] FAIL full_protocol: got %0d overlaps expected 0", viol); end
        checks++; if (wr_log.size() != NUM_ROWS) begin errors++; $display("[TB] FAIL full_write_count: got %0d expected %0d", wr_log.size(), NUM_ROWS); end
        for (int i = 0; i < wr_log.size() && i < NUM_ROWS; i++) begin
            checks++;
            if (wr_log[i] != i) begin errors++; $display("[TB] FAIL full_write_order %0d: got %0d expected %0d", i, wr_log[i], i); end
        end
    endtask

    task automatic test_random();
        int d_at;
        int b_cnt;
        bit to;
        for (int it = 0; it < 3; it++) begin
            fill_random();
            build_expected();
            run_pass(d_at, b_cnt, to);
            checks++; if (to !== 1'b0) begin errors++; $display("[TB] FAIL rand_timeout: got %b expected 0", to); end
            check_rows("rand");
            checks++;
            if (clip_cnt !== 8'(exp_clip)) begin
                errors++;
                $display("[TB] FAIL rand_clip_cnt: got %0d expected %0d", clip_cnt, exp_clip);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_start_ignored();
        int pulses;
        int b_cnt;
        fill_random();
        build_expected();
        wr_log.delete();
        pulses = 0;
        b_cnt  = 0;
        start  = 1'b1;
        @(negedge clk);
        for (int c = 1; c <= 70; c++) begin
            start = (c == 9 || c == 47 || c == 48);
            if (busy) b_cnt++;
            if (done) pulses++;
            @(negedge clk);
        end
        start = 1'b0;
        checks++; if (pulses != 1) begin errors++; $display("[TB] FAIL ignore_done_pulses: got %0d expected 1", pulses); end
        checks++; if (b_cnt != 48) begin errors++; $display("[TB] FAIL ignore_busy_cycles: got %0d expected 48", b_cnt); end
        checks++; if (wr_log.size() != NUM_ROWS) begin errors++; $display("[TB] FAIL ignore_write_count: got %0d expected %0d", wr_log.size(), NUM_ROWS); end
        check_rows("ignore");
    endtask

    task automatic test_reset_mid_pass();
        int        d_at;
        int        b_cnt;
        bit        to;
        psum_row_t once[NUM_ROWS];
        fill_random();
        build_expected();
        for (int i = 0; i < NUM_ROWS; i++) once[i] = exp_mem[i];
        wr_log.delete();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        checks++; if (busy !== 1'b0)        begin errors++; $display("[TB] FAIL midrst_busy: got %b expected 0", busy); end
        checks++; if (sif.op_cen !== 1'b1)  begin errors++; $display("[TB] FAIL midrst_op_cen: got %b expected 1", sif.op_cen); end
        checks++; if (sif.op_wen !== 1'b1)  begin errors++; $display("[TB] FAIL midrst_op_wen: got %b expected 1", sif.op_wen); end
        checks++; if (sif.res_cen !== 1'b1) begin errors++; $display("[TB] FAIL midrst_res_cen: got %b expected 1", sif.res_cen); end
        checks++; if (sif.res_addr !== 4'd0) begin errors++; $display("[TB] FAIL midrst_res_addr: got %h expected 0", sif.res_addr); end
        checks++; if (sif.op_d !== '0)      begin errors++; $display("[TB] FAIL midrst_op_d: got %h expected 0", sif.op_d); end
        checks++; if (clip_cnt !== 8'd0)    begin errors++; $display("[TB] FAIL midrst_clip_cnt: got %0d expected 0", clip_cnt); end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++; if (wr_log.size() != 6) begin errors++; $display("[TB] FAIL midrst_write_count: got %0d expected 6", wr_log.size()); end
        for (int i = 0; i < NUM_ROWS; i++) exp_mem[i] = (i < 6) ? once[i] : orig_mem[i];
        check_rows("midrst_partial");
        build_expected();
        run_pass(d_at, b_cnt, to);
        checks++; if (to !== 1'b0) begin errors++; $display("[TB] FAIL midrst_rerun_timeout: got %b expected 0", to); end
        checks++; if (wr_log.size() == 0 || wr_log[0] != 0) begin errors++; $display("[TB] FAIL midrst_rerun_first_row: got size %0d expected first write at row 0", wr_log.size()); end
        check_rows("midrst_rerun");
        @(negedge clk);
    endtask

    initial begin
        $display("[TB] residual_relu_unit bench starting");
        test_reset();
        test_directed_row0();
        test_full_pass();
        test_random();
        test_start_ignored();
        test_reset_mid_pass();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
